// File: rtl/uart_rx_os.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_os                                                    |
// | Purpose  : Oversampling UART receiver. Each bit is sampled once, in the  |
// |            middle of the bit, and every word is handed off through a     |
// |            one-entry valid/ready holding register. Errors are sticky.    |
// | Ports    : clk        system clock (rising edge)                          |
// |            reset_p    asynchronous active-high reset                     |
// |            RX         asynchronous serial line, idle high                |
// |            rx_data    last received word, held while rx_valid=1          |
// |            rx_valid   holding register full                              |
// |            rx_ready   consumer accepts (transfer on valid & ready)       |
// |            frame_err  sticky, stop bit sampled low                       |
// |            overrun    sticky, word completed while holding reg full      |
// |            parity_err sticky, parity mismatch (parity build only)        |
// |            err_clr    one-cycle pulse clearing the sticky flags          |
// | Options  : define UART_RX_PARITY_EN to add the parity bit, the           |
// |            ODD_PARITY parameter and the parity_err output.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx_os #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
`ifdef UART_RX_PARITY_EN
    parameter int ODD_PARITY = 0,
`endif
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    input  logic                 err_clr
);

    localparam int c_div_raw = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int c_div     = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_div_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_os_w    = $clog2(OVERSAMPLE);
    localparam int c_bit_w   = $clog2(DATA_BITS);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_os_w-1:0]  c_os_mid   = c_os_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_os_w-1:0]  c_os_last  = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic       c_odd       = (ODD_PARITY != 0);
`endif
    localparam logic [2:0] c_st_stop   = 3'd4;

    // Two-flop synchroniser plus one history flop for edge detection
    logic r_sync1, r_sync2, r_sync_prev;
    logic w_fall;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= RX;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // A falling edge needs the line to have been high first, so after a
    // bad stop bit the receiver naturally waits for the line to return high.
    assign w_fall = r_sync_prev & ~r_sync2;

    // Free-running oversample tick
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;

    assign w_tick = (r_div_cnt == c_div_last);

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    // Receive FSM and output registers
    logic [2:0]           r_state;
    logic [c_os_w-1:0]    r_os_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_handshake;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_parity_err;
    logic                 w_par_bad_now;

    // Total ones over data and parity bit must match the selected sense
    assign w_par_bad_now = (^r_shift) ^ r_sync2 ^ c_odd;
    assign parity_err    = r_parity_err;
`endif

    assign w_handshake = r_rx_valid & rx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state      <= c_st_idle;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Later assignments below override these, so a completion in
            // the handshake cycle keeps rx_valid high and a new error
            // coincident with err_clr keeps its flag set.
            if (w_handshake) begin
                r_rx_valid <= 1'b0;
            end
            if (err_clr) begin
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end

            case (r_state)
                c_st_idle: begin
                    if (w_fall) begin
                        r_state  <= c_st_start;
                        r_os_cnt <= '0;
                    end
                end

                c_st_start: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_os_mid) begin
                            r_os_cnt <= '0;
                            if (!r_sync2) begin
                                r_state   <= c_st_data;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= c_st_idle;  // glitch
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + c_os_w'(1);
                        end
                    end
                end

                c_st_data: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_os_last) begin
                            r_os_cnt  <= '0;
                            r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                            if (r_bit_cnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= c_st_parity;
`else
                                r_state <= c_st_stop;
`endif
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + c_os_w'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                c_st_parity: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_os_last) begin
                            r_os_cnt  <= '0;
                            r_par_bad <= w_par_bad_now;
                            r_state   <= c_st_stop;
                        end else begin
                            r_os_cnt <= r_os_cnt + c_os_w'(1);
                        end
                    end
                end
`endif

                c_st_stop: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_os_last) begin
                            r_os_cnt <= '0;
                            r_state  <= c_st_idle;
                            if (r_sync2) begin
                                // Slot is free now or is being emptied this cycle
                                if (!r_rx_valid || rx_ready) begin
                                    r_rx_data  <= r_shift;
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
`ifdef UART_RX_PARITY_EN
                                if (r_par_bad) begin
                                    r_parity_err <= 1'b1;
                                end
`endif
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + c_os_w'(1);
                        end
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter CLK_HZ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, range 5..9, data bits per frame, LSB first.
REQ-004 Parameter OVERSAMPLE, default 16, even value 8..16, sample ticks per bit.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset_p  input  1  reset, asynchronous and active-high.
REQ-007 RX  input  1  asynchronous serial line; idle high.
REQ-008 rx_data  output  DATA_BITS  last received word, held while rx_valid=1.
REQ-009 rx_valid  output  1  holding register full.
REQ-010 rx_ready  input  1  consumer accepts; transfer occurs when rx_valid&rx_ready are both high.
REQ-011 frame_err  output  1  sticky; stop bit sampled low.
REQ-012 overrun  output  1  sticky; frame completed while holding register still full.
REQ-013 err_clr  input  1  one-cycle pulse; clears frame_err, overrun and parity_err.

Function
REQ-014 RX SHALL pass through a 2-flop synchroniser before any use; the synchronised line adds 2 cycles of latency.
REQ-015 Tick divisor SHALL be CLK_HZ/(BAUD*OVERSAMPLE), integer floor, minimum 1; the tick counter wraps to 0 after divisor-1 and free-runs.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY (present only with the macro), and STOP.
REQ-017 IDLE->START on a synchronised falling edge; the sample counter is cleared.
REQ-018 In START, at tick count OVERSAMPLE/2-1 the line is sampled: low -> DATA with the counter cleared; high -> IDLE (glitch rejected, no flag).
REQ-019 DATA SHALL sample every OVERSAMPLE ticks at mid-bit and shift each bit into bit position DATA_BITS-1 moving right (LSB first); after DATA_BITS samples -> PARITY or STOP.
REQ-020 STOP samples at mid-bit; on the sample the FSM returns to IDLE and can detect a new start edge in the next cycle.
REQ-021 Stop bit high: the word SHALL load rx_data and set rx_valid on the cycle after the stop sample.
REQ-022 Stop bit low: frame_err SHALL be set, the word is discarded, and the FSM waits in IDLE for the line to go high before arming the edge detector.
REQ-023 Completion with rx_valid=1 and no handshake in that cycle: overrun SHALL be set, the new word is dropped, and rx_data is unchanged.
REQ-024 Completion in the same cycle as a handshake: the new word SHALL load, rx_valid stays 1, and no overrun is flagged.
REQ-025 Handshake without completion SHALL clear rx_valid on the next cycle.
REQ-026 err_clr coincident with a new error event: the new error wins and the flag stays set.

Reset
REQ-027 While reset_p=1: FSM=IDLE, all counters 0, synchroniser flops=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output or flag change beyond the reset values; after release the first falling edge starts a new frame.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: the PARITY state and an output parity_err (1 bit, sticky) SHALL exist. Parameter ODD_PARITY (default 0) selects odd or even parity. On a parity mismatch the word still loads and parity_err is set.
REQ-030 UART_RX_PARITY_EN undefined: no PARITY state and no parity_err port; DATA goes directly to STOP.

Verification
REQ-031 Baseline bench settings: CLK_HZ=16_000_000, BAUD=1_000_000, OVERSAMPLE=16 (divisor 1, 16 clk/bit); 10-cycle reset.
REQ-032 Send frames 0x30,0x31,0x32,0x33,0x34 back-to-back with rx_ready=1 -> five rx_valid pulses carrying those values in order; no flags set.
REQ-033 Low pulse of 4 clk on an idle line -> no rx_valid, FSM back in IDLE, no flags.
REQ-034 Send 0x55 with the stop bit forced low -> frame_err=1, rx_valid=0; line high then 0xA5 -> rx_data=0xA5; err_clr -> frame_err=0.
REQ-035 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, overrun=1; rx_ready=1 -> rx_valid drops after one cycle.
REQ-036 Assert reset_p during bit 3 of 0xF0 -> all outputs 0; after release send 0x0F -> rx_data=0x0F.
REQ-037 With UART_RX_PARITY_EN and even parity, send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1.
